// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: turns START/STOP/WRITE/READ commands into four
// quarter-bit phases of SCL/SDA open-drain drive, with clock stretching,
// read sampling and arbitration-loss detection.
//
// state | meaning
// IDLE  | waiting for a command; lines hold the last PH3 drive
// PH0   | first quarter (accept cycle counts as its first cycle)
// PH1   | second quarter, SCL released for data bits; stretch/arbitration
// PH2   | third quarter; READ samples SDA on its last cycle
// PH3   | fourth quarter; done pulses on the cycle after it ends
module i2c_bit_sequencer #(
  parameter int QTR_CYCLES = 20
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       wr_bit,
  output logic       done,
  output logic       rd_bit,
  output logic       arb_lost,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int CW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  // The accept cycle already counts toward PH0, so PH0 loads one less.
  localparam logic [CW-1:0] LD_FIRST = CW'(QTR_CYCLES - 2);
  localparam logic [CW-1:0] LD_FULL  = CW'(QTR_CYCLES - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH0  = 3'd1,
    S_PH1  = 3'd2,
    S_PH2  = 3'd3,
    S_PH3  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    cmd_q;
  logic          wr_q;
  logic [1:0]    ph_idx;
  logic [1:0]    tgt;
  logic          accept, stretch, phase_end, arb_hit;
  logic          scl_oe_nx, sda_oe_nx, done_nx, rd_latch;

  // Target {SCL, SDA} levels for a command in a given quarter.
  function automatic logic [1:0] line_target(input logic [1:0] c, input logic b,
                                             input logic [1:0] ph);
    logic [1:0] t;
    logic       mid;
    mid = (ph == 2'd1) || (ph == 2'd2);
    case (c)
      CMD_START: t = (ph == 2'd2) ? 2'b10 : ((ph == 2'd3) ? 2'b00 : 2'b11);
      CMD_STOP:  t = (ph == 2'd0) ? 2'b00 : ((ph == 2'd3) ? 2'b11 : 2'b10);
      CMD_WRITE: t = {mid, b};
      default:   t = {mid, 1'b1};
    endcase
    return t;
  endfunction

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // The drive register lags the state by a cycle, so a stretch is only a
  // stretch once our own SCL pull-down from PH0 has actually been released.
  assign stretch   = ((state == S_PH1) || (state == S_PH2)) && !scl_in && !scl_oe;
  assign phase_end = (cnt == '0) && !stretch;
  assign arb_hit   = ((state == S_PH1) || (state == S_PH2)) && (cmd_q == CMD_WRITE)
                     && wr_q && !sda_in && scl_in;

  // Quarter index of the current phase state.
  always_comb begin
    ph_idx = 2'd0;
    case (state)
      S_PH1:   ph_idx = 2'd1;
      S_PH2:   ph_idx = 2'd2;
      S_PH3:   ph_idx = 2'd3;
      default: ph_idx = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: phases advance on counter terminal count; arbitration aborts.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_PH0;
      S_PH0:  if (phase_end) state_nx = S_PH1;
      S_PH1:  if (arb_hit) state_nx = S_IDLE;
              else if (phase_end) state_nx = S_PH2;
      S_PH2:  if (arb_hit) state_nx = S_IDLE;
              else if (phase_end) state_nx = S_PH3;
      S_PH3:  if (phase_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output/datapath next values: counter, line drive, done and read sample.
  always_comb begin
    tgt       = line_target(cmd_q, wr_q, ph_idx);
    cnt_nx    = cnt;
    scl_oe_nx = scl_oe;
    sda_oe_nx = sda_oe;
    done_nx   = 1'b0;
    rd_latch  = 1'b0;
    if (accept) begin
      tgt       = line_target(cmd, wr_bit, 2'd0);
      cnt_nx    = LD_FIRST;
      scl_oe_nx = ~tgt[1];
      sda_oe_nx = ~tgt[0];
    end else if (state != S_IDLE) begin
      if (arb_hit) begin
        cnt_nx    = '0;
        scl_oe_nx = 1'b0;
        sda_oe_nx = 1'b0;
        done_nx   = 1'b1;
      end else begin
        scl_oe_nx = ~tgt[1];
        sda_oe_nx = ~tgt[0];
        if (phase_end) begin
          cnt_nx   = (state == S_PH3) ? '0 : LD_FULL;
          done_nx  = (state == S_PH3);
          rd_latch = (state == S_PH2) && (cmd_q == CMD_READ);
        end else if (!stretch) begin
          cnt_nx = cnt - 1'b1;
        end
      end
    end
  end

  // Registered datapath: counter, latched command, line drive and status flags.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt      <= '0;
      cmd_q    <= CMD_START;
      wr_q     <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      rd_bit   <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      scl_oe <= scl_oe_nx;
      sda_oe <= sda_oe_nx;
      done   <= done_nx;
      if (accept) begin
        cmd_q <= cmd;
        wr_q  <= wr_bit;
      end
      if (rd_latch) rd_bit <= sda_in;
      if (arb_hit) arb_lost <= 1'b1;
      else if (accept && (cmd == CMD_START)) arb_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Scoreboard bench for i2c_bit_sequencer: directed corner cases followed by
// random command streams, checked against a phase-table reference model.
module tb_i2c_bit_sequencer;

  localparam int Q = 4;
  localparam int C_START = 0, C_STOP = 1, C_WRITE = 2, C_READ = 3;

  logic       CLK = 1'b0;
  logic       rst, cmd_valid, cmd_ready, wr_bit, done, rd_bit, arb_lost;
  logic [1:0] cmd;
  logic       scl_in, sda_in, scl_oe, sda_oe;
  logic       scl_hold, sda_pull;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int cyc; logic rd; logic arb; logic scl; logic sda; } exp_done_t;
  typedef struct { int cyc; logic scl; logic sda; } exp_line_t;
  exp_done_t sbq[$];
  exp_line_t lq[$];
  exp_done_t mon_e;
  exp_line_t mon_l;

  logic m_rd  = 1'b0;
  logic m_arb = 1'b0;

  // Line levels per quarter, straight from the command table (WRITE SDA = data bit).
  int scl_tab [4][4] = '{'{1,1,1,0}, '{0,1,1,1}, '{0,1,1,0}, '{0,1,1,0}};
  int sda_tab [4][4] = '{'{1,1,0,0}, '{0,0,0,1}, '{0,0,0,0}, '{1,1,1,1}};

  i2c_bit_sequencer #(.QTR_CYCLES(Q)) dut (
    .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .wr_bit(wr_bit), .done(done), .rd_bit(rd_bit),
    .arb_lost(arb_lost), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  // Open-drain bus: line is low if anyone pulls it.
  assign scl_in = !scl_oe && !scl_hold;
  assign sda_in = !sda_oe && !sda_pull;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [1:0] ref_target(input int c, input logic b, input int p);
    logic s, d;
    s = (scl_tab[c][p] != 0);
    d = (c == C_WRITE) ? b : (sda_tab[c][p] != 0);
    return {s, d};
  endfunction

  task automatic goto(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // Offer a command, wait for accept, and record what must follow.
  // done_off < 0 means no done pulse is expected (reset abort).
  task automatic issue(input int c, input logic b, input logic rb, input int nlines,
                       input int done_off, input logic abort, output int acc);
    int n;
    logic [1:0] t;
    exp_done_t e;
    cmd_valid = 1'b1;
    cmd       = 2'(c);
    wr_bit    = b;
    n = 0;
    while (!cmd_ready) begin
      @(negedge CLK);
      n++;
      if (n > 200) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
    acc = cyc;
    sda_pull = (c == C_READ) ? !rb : 1'b0;
    if (c == C_START) m_arb = 1'b0;
    e.cyc = acc + done_off;
    if (abort) begin
      m_arb = 1'b1;
      e.scl = 1'b0;
      e.sda = 1'b0;
    end else begin
      t = ref_target(c, b, 3);
      e.scl = !t[1];
      e.sda = !t[0];
      if (c == C_READ) m_rd = rb;
    end
    e.arb = m_arb;
    e.rd  = m_rd;
    if (done_off >= 0) sbq.push_back(e);
    for (int k = 1; k <= nlines; k++) begin
      exp_line_t l;
      t = ref_target(c, b, (k - 1) / Q);
      l.cyc = acc + k;
      l.scl = !t[1];
      l.sda = !t[0];
      lq.push_back(l);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom_range(0, 3));
    wr_bit    = 1'($urandom_range(0, 1));
  endtask

  // Done monitor: every done pulse must match the oldest expected completion.
  always @(negedge CLK) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("rd_bit", rd_bit, mon_e.rd);
        chk("arb_lost", arb_lost, mon_e.arb);
        chk("done_scl_oe", scl_oe, mon_e.scl);
        chk("done_sda_oe", sda_oe, mon_e.sda);
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      mon_e = sbq.pop_front();
      chk("done_missed", cyc, mon_e.cyc);
    end
  end

  // Line monitor: per-cycle open-drain drive during tracked commands.
  always @(negedge CLK) begin
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      mon_l = lq.pop_front();
      chk($sformatf("scl_oe@%0d", mon_l.cyc), scl_oe, mon_l.scl);
      chk($sformatf("sda_oe@%0d", mon_l.cyc), sda_oe, mon_l.sda);
    end
  end

  initial begin
    int a1, a2, a3, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; wr_bit = 1'b0;
    scl_hold = 1'b0; sda_pull = 1'b0;

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_bit", rd_bit, 0);
    chk("rst_arb", arb_lost, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    // START: sda_oe rises at +9, scl_oe at +13, done at +16 only
    issue(C_START, 1'b0, 1'b0, 16, 16, 1'b0, a1);
    goto(a1 + 15);
    chk("start_done_early", done, 0);
    goto(a1 + 16);
    chk("start_done", done, 1);
    chk("start_ready_b2b", cmd_ready, 1);
    goto(a1 + 17);

    // WRITE 0 then READ back-to-back, slave drives 0
    issue(C_WRITE, 1'b0, 1'b0, 16, 16, 1'b0, a1);
    issue(C_READ, 1'b0, 1'b0, 16, 16, 1'b0, a2);
    chk("b2b_accept_gap", a2 - a1, 16);
    goto(a2 + 17);

    // READ stretched 10 cycles in PH1, slave drives 1
    issue(C_READ, 1'b0, 1'b1, 4, 26, 1'b0, a1);
    goto(a1 + 5);
    scl_hold = 1'b1;
    goto(a1 + 15);
    scl_hold = 1'b0;
    goto(a1 + 27);

    // WRITE 1 loses arbitration in PH1; sticky through STOP, cleared by START
    issue(C_WRITE, 1'b1, 1'b0, 5, 6, 1'b1, a1);
    goto(a1 + 5);
    chk("arb_before", arb_lost, 0);
    sda_pull = 1'b1;
    goto(a1 + 6);
    chk("arb_set", arb_lost, 1);
    chk("arb_ready", cmd_ready, 1);
    goto(a1 + 7);
    sda_pull = 1'b0;
    chk("arb_done_pulse", done, 0);
    issue(C_STOP, 1'b0, 1'b0, 16, 16, 1'b0, a2);
    goto(a2 + 16);
    issue(C_START, 1'b0, 1'b0, 16, 16, 1'b0, a3);
    chk("arb_cleared", arb_lost, 0);
    goto(a3 + 17);

    // reset pulse during PH2 of STOP
    issue(C_STOP, 1'b0, 1'b0, 9, -1, 1'b0, a1);
    goto(a1 + 9);
    rst = 1'b1;
    #1 chk("ready_in_rst", cmd_ready, 0);
    goto(a1 + 10);
    chk("abort_scl_oe", scl_oe, 0);
    chk("abort_sda_oe", sda_oe, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_bit", rd_bit, 0);
    rst = 1'b0;
    m_rd = 1'b0;
    m_arb = 1'b0;
    #1 chk("ready_after_abort", cmd_ready, 1);
    repeat (20) begin
      @(negedge CLK);
      chk("no_done_after_abort", done, 0);
    end

    // random command stream
    for (int i = 0; i < 40; i++) begin
      int c;
      logic b, rb;
      c  = $urandom_range(0, 3);
      b  = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      issue(c, b, rb, 16, 16, 1'b0, a1);
      n = $urandom_range(0, 20);
      repeat (n) @(negedge CLK);
    end

    n = 0;
    while ((sbq.size() > 0 || lq.size() > 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", sbq.size() + lq.size(), 0);
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
